// File: rtl/div_repeated_sub.sv
// Unsigned repeated-subtraction divider with a two-cycle serial operand load
// (dividend, then divisor) over the shared data_in bus; start/done handshake.
module div_repeated_sub #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             done,
   output logic             busy,
   output logic             dbz
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_A,
      S_LOAD_B,
      S_SUB,
      S_DONE
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] q_q;
   logic             done_q;
   logic             busy_q;
   logic             dbz_q;

   logic [WIDTH-1:0] diff_d;
   logic [WIDTH-1:0] qinc_d;

   // R >= B is checked before diff_d is used, so the subtraction never wraps.
   assign diff_d = r_q - b_q;
   assign qinc_d = q_q + WIDTH'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         r_q     <= '0;
         b_q     <= '0;
         q_q     <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_LOAD_A;
                  busy_q  <= 1'b1;
               end
            end
            S_LOAD_A: begin
               r_q     <= data_in;
               q_q     <= '0;
               dbz_q   <= 1'b0;
               state_q <= S_LOAD_B;
            end
            S_LOAD_B: begin
               b_q     <= data_in;
               state_q <= S_SUB;
            end
            S_SUB: begin
               if (b_q == '0) begin
                  dbz_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else if (r_q >= b_q) begin
                  r_q <= diff_d;
                  q_q <= qinc_d;
               end else begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               // start must be released before another operation can begin
               if (!start) begin
                  done_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign quotient  = q_q;
   assign remainder = r_q;
   assign done      = done_q;
   assign busy      = busy_q;
   assign dbz       = dbz_q;

endmodule
